matrix_vector_mac: RTL and testbench

- Downstream consumer of the matrix FIFO in the P03 matrix-vector datapath.
- Once the FIFO pointer logic reports a full N×N matrix stored, this block pops elements in row-major order.
- Each row is multiply-accumulated against a locally stored N-element vector.
- Each row result is presented over a valid/ack handshake to the output/UART formatting stage.

---
 rtl/matrix_vector_mac.sv | 166 ++++++++++++++++
 tb/tb_matrix_vector_mac.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_vector_mac.sv
// Row-wise matrix-vector multiply-accumulate. It pops an NxN matrix in row-major order from a
// show-ahead FIFO and returns one dot product per row, against a stored vector, over valid/ack.
module matrix_vector_mac #(
    parameter int DATA_W = 8,
    parameter int NMAX   = 8,
    parameter int ACC_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        N,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    input  logic              vec_wr,
    input  logic [2:0]        vec_addr,
    input  logic [DATA_W-1:0] vec_data,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    output logic [2:0]        res_idx,
    input  logic              res_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int              IDX_W  = 3;
    localparam int              NW     = 4;
    localparam logic [NW-1:0]   NMAX_N = NW'(NMAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NW-1:0]      n_q, n_d;
    logic [IDX_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   col_q, col_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic               res_valid_q, busy_q, done_q, err_q, err_d;
    logic               pop_s, n_ok_s, last_col_s, last_row_s, vec_we_s;
    logic [ACC_W-1:0]   prod_s, sum_s;
    logic [DATA_W-1:0]  vec_q [NMAX];

    assign n_ok_s     = (N != 4'd0) && (N <= NMAX_N);
    assign last_col_s = ({1'b0, col_q} == (n_q - 4'd1));
    assign last_row_s = ({1'b0, row_q} == (n_q - 4'd1));
    assign prod_s     = ACC_W'(fifo_data) * ACC_W'(vec_q[col_q]);
    assign sum_s      = acc_q + prod_s;
    assign vec_we_s   = (state_q == ST_IDLE) && vec_wr && ({1'b0, vec_addr} < NMAX_N);

    // Next-state, datapath and pop decode
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        row_d      = row_q;
        col_d      = col_q;
        acc_d      = acc_q;
        res_data_d = res_data_q;
        res_idx_d  = res_idx_q;
        err_d      = 1'b0;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && n_ok_s) begin
                    n_d     = N;
                    row_d   = {IDX_W{1'b0}};
                    col_d   = {IDX_W{1'b0}};
                    acc_d   = {ACC_W{1'b0}};
                    state_d = ST_MAC;
                end else if (start) begin
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (!fifo_empty) begin
                    pop_s = 1'b1;
                    acc_d = sum_s;
                    if (last_col_s) begin
                        res_data_d = sum_s;
                        res_idx_d  = row_q;
                        state_d    = ST_OUT;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_OUT: begin
                if (res_ack) begin
                    acc_d = {ACC_W{1'b0}};
                    col_d = {IDX_W{1'b0}};
                    if (last_row_s) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + 3'd1;
                        state_d = ST_MAC;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs; flags follow the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            n_q         <= {NW{1'b0}};
            row_q       <= {IDX_W{1'b0}};
            col_q       <= {IDX_W{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            res_data_q  <= {ACC_W{1'b0}};
            res_idx_q   <= {IDX_W{1'b0}};
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            row_q       <= row_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_valid_q <= (state_d == ST_OUT);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            err_q       <= err_d;
        end
    end

    // Vector store, writable only while idle so it stays frozen during a run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NMAX; i++) begin
                vec_q[i] <= {DATA_W{1'b0}};
            end
        end else if (vec_we_s) begin
            vec_q[vec_addr] <= vec_data;
        end else begin
            vec_q <= vec_q;
        end
    end

    assign fifo_pop  = pop_s;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matrix_vector_mac.sv
// Randomized bench for matrix_vector_mac: a FIFO model feeds the DUT and a monitor compares
// every accepted row result against dot products computed directly from the matrix and vector.
module tb_matrix_vector_mac;

    localparam int DATA_W = 8;
    localparam int NMAX   = 8;
    localparam int ACC_W  = 19;

    logic              clk = 1'b0;
    logic              rst, start, fifo_empty, fifo_pop, vec_wr;
    logic              res_valid, res_ack, busy, done, err;
    logic [3:0]        N;
    logic [DATA_W-1:0] fifo_data, vec_data;
    logic [2:0]        vec_addr, res_idx;
    logic [ACC_W-1:0]  res_data;

    int        n_checks = 0;
    int        n_errors = 0;
    logic [7:0] fifo_mem [4096];
    int        wr_ptr = 0, rd_ptr = 0, pop_cnt = 0, stall_at = -1, stall_cyc = 0;
    int        exp_val [1024];
    int        exp_idx [1024];
    int        len_arr [1024];
    int        exp_wr = 0, res_rd = 0;
    int        done_cnt = 0, err_cnt = 0, n_cur = 1, bp_len = 0;
    bit        rand_ack = 1'b0;
    int        vec_m [8];
    int        mat [64];
    logic      stall_s;

    matrix_vector_mac #(.DATA_W(DATA_W), .NMAX(NMAX), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .N(N),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .vec_wr(vec_wr), .vec_addr(vec_addr), .vec_data(vec_data),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx), .res_ack(res_ack),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign stall_s    = (pop_cnt == stall_at) && (stall_cyc < 3);
    assign fifo_empty = (rd_ptr >= wr_ptr) || stall_s;
    assign fifo_data  = fifo_mem[rd_ptr[11:0]];

    // Show-ahead FIFO model; reset discards whatever the aborted run left behind
    always @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_pop) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (pop_cnt == stall_at) stall_cyc <= stall_cyc + 1;
        else stall_cyc <= 0;
    end

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer: random or tied-high ack, optionally refusing row 0 for bp_len cycles
    initial begin : ack_driver
        int vcnt;
        vcnt = 0;
        res_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (res_valid) vcnt++;
            else vcnt = 0;
            if (bp_len > 0 && res_valid && res_idx == 3'd0 && vcnt <= bp_len) res_ack = 1'b0;
            else if (rand_ack) res_ack = 1'($urandom_range(0, 1));
            else res_ack = 1'b1;
        end
    end

    // Monitor: result scoreboard, handshake stability, pop legality, done/err pulses
    initial begin : monitor
        bit prev_v, prev_last;
        int prev_data, prev_idx, mlen;
        prev_v = 1'b0; prev_last = 1'b0; prev_data = 0; prev_idx = 0; mlen = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                res_rd = exp_wr;
                prev_v = 1'b0; prev_last = 1'b0; mlen = 0;
            end else begin
                if (fifo_empty) check_eq("pop_when_empty", int'(fifo_pop), 0);
                if (res_valid) check_eq("pop_in_out", int'(fifo_pop), 0);
                if (prev_last || done) check_eq("done_timing", int'(done), int'(prev_last));
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (res_valid && prev_v) begin
                    check_eq("res_data_stable", int'(res_data), prev_data);
                    check_eq("res_idx_stable", int'(res_idx), prev_idx);
                end
                prev_last = 1'b0;
                if (res_valid) begin
                    mlen++;
                    if (res_ack) begin
                        if (res_rd >= exp_wr) begin
                            check_eq("unexpected_result", int'(res_data), -1);
                        end else begin
                            check_eq("res_idx", int'(res_idx), exp_idx[res_rd]);
                            check_eq("res_data", int'(res_data), exp_val[res_rd]);
                            len_arr[res_rd] = mlen;
                            res_rd++;
                        end
                        prev_last = (int'(res_idx) == n_cur - 1);
                        prev_v = 1'b0;
                        mlen = 0;
                    end else begin
                        prev_v = 1'b1;
                        prev_data = int'(res_data);
                        prev_idx = int'(res_idx);
                    end
                end else begin
                    prev_v = 1'b0;
                    mlen = 0;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_flags"}, int'({busy, res_valid, fifo_pop, done, err}), 0);
        check_eq({tag, "_res_data"}, int'(res_data), 0);
        check_eq({tag, "_res_idx"}, int'(res_idx), 0);
    endtask

    // One accepted start: model results, fill FIFO, launch, then wait for done or abort by reset
    task automatic run_job(input int n, input bit wr_vec, input bit wr_busy, input int abort_at);
        int pops0, done0, s, idx;
        for (int r = 0; r < n; r++) begin
            s = 0;
            for (int c = 0; c < n; c++) s += mat[r*n + c] * vec_m[c];
            exp_val[exp_wr + r] = s;
            exp_idx[exp_wr + r] = r;
        end
        exp_wr += n;
        for (int k = 0; k < n*n; k++) begin
            idx = wr_ptr + k;
            fifo_mem[idx[11:0]] = 8'(mat[k]);
        end
        wr_ptr += n*n;
        n_cur = n;
        pops0 = pop_cnt;
        done0 = done_cnt;
        if (wr_vec) begin
            for (int i = 0; i < 8; i++) begin
                vec_wr = 1'b1; vec_addr = 3'(i); vec_data = 8'(vec_m[i]);
                if (i == 7) begin start = 1'b1; N = 4'(n); end
                tick();
            end
        end else begin
            start = 1'b1; N = 4'(n);
            tick();
        end
        start = 1'b0; vec_wr = 1'b0;
        N = 4'($urandom_range(0, 15));
        if (wr_busy) begin
            vec_wr = 1'b1; vec_addr = 3'($urandom_range(0, 7)); vec_data = 8'($urandom);
            tick();
            vec_wr = 1'b0;
        end
        if (abort_at >= 0) begin
            for (int t = 0; t < 2000 && pop_cnt < pops0 + abort_at; t++) tick();
            check_eq("abort_point_reached", int'(pop_cnt >= pops0 + abort_at), 1);
            rst = 1'b0;
            #1;
            check_all_zero("mid_reset");
            tick(); tick();
            rst = 1'b1;
            tick();
            check_all_zero("after_reset");
        end else begin
            for (int t = 0; t < 3000 && done_cnt == done0; t++) tick();
            check_eq("done_pulses", done_cnt - done0, 1);
            check_eq("pop_count", pop_cnt - pops0, n*n);
            check_eq("busy_after_done", int'(busy), 0);
            check_eq("results_received", res_rd, exp_wr);
        end
    endtask

    task automatic rand_data(input int n);
        for (int i = 0; i < 8; i++) vec_m[i] = int'($urandom_range(0, 255));
        for (int k = 0; k < n*n; k++) mat[k] = int'($urandom_range(0, 255));
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        int bad_n [3];
        int e0, p0, b;
        bad_n[0] = 0; bad_n[1] = 9; bad_n[2] = 15;
        rst = 1'b0; start = 1'b0; N = 4'd0; vec_wr = 1'b0; vec_addr = 3'd0; vec_data = 8'd0;
        repeat (3) tick();
        check_all_zero("reset_state");
        rst = 1'b1;
        tick();

        // Illegal N with data sitting in the FIFO: must flag err and never pop
        for (int k = 0; k < 3; k++) fifo_mem[k] = 8'(k + 7);
        wr_ptr = 3;
        for (int j = 0; j < 3; j++) begin
            e0 = err_cnt; p0 = pop_cnt;
            start = 1'b1; N = 4'(bad_n[j]);
            tick();
            start = 1'b0;
            check_eq("illegal_busy", int'(busy), 0);
            tick(); tick();
            check_eq("illegal_err_pulses", err_cnt - e0, 1);
            check_eq("illegal_pops", pop_cnt - p0, 0);
            check_eq("illegal_busy_late", int'(busy), 0);
        end
        rst = 1'b0; tick(); rst = 1'b1; tick();

        // Basic 2x2
        for (int i = 0; i < 8; i++) vec_m[i] = 0;
        vec_m[0] = 1; vec_m[1] = 2;
        for (int k = 0; k < 4; k++) mat[k] = k + 1;
        run_job(2, 1'b1, 1'b0, -1);

        // FIFO empty for 3 cycles in the middle of row 1
        for (int i = 0; i < 8; i++) vec_m[i] = (i < 3) ? 1 : 0;
        for (int k = 0; k < 9; k++) mat[k] = k + 1;
        stall_at = pop_cnt + 4;
        run_job(3, 1'b1, 1'b0, -1);
        stall_at = -1;

        // Backpressure on row 0
        rand_data(2);
        bp_len = 5;
        b = exp_wr;
        run_job(2, 1'b1, 1'b0, -1);
        check_eq("bp_row0_valid_cycles", len_arr[b], 6);
        bp_len = 0;

        // Full-scale operands
        for (int i = 0; i < 8; i++) vec_m[i] = 255;
        for (int k = 0; k < 64; k++) mat[k] = 255;
        run_job(8, 1'b1, 1'b0, -1);

        // Vector write while busy is ignored, and the vector persists into the next run
        rand_data(3);
        run_job(3, 1'b1, 1'b1, -1);
        for (int k = 0; k < 9; k++) mat[k] = int'($urandom_range(0, 255));
        run_job(3, 1'b0, 1'b0, -1);

        // Reset during row 1 of a 3x3 run, then the vector must read back as zero
        rand_data(3);
        run_job(3, 1'b1, 1'b0, 4);
        for (int i = 0; i < 8; i++) vec_m[i] = 0;
        for (int k = 0; k < 4; k++) mat[k] = int'($urandom_range(1, 255));
        run_job(2, 1'b0, 1'b0, -1);

        // Randomized runs with random acknowledge
        rand_ack = 1'b1;
        for (int j = 0; j < 6; j++) begin
            b = int'($urandom_range(1, 8));
            rand_data(b);
            run_job(b, 1'b1, 1'($urandom_range(0, 1)), -1);
        end
        rand_ack = 1'b0;

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
